// File: rtl/phy_pipe_pkg.sv
// Shared PIPE RX definitions: status width, status code ordering (larger = more severe),
// and the DataBusWidth-to-byte-count mapping used by the receive packer.
package phy_pipe_pkg;

    localparam int STATUS_W = 3;

    typedef enum logic [STATUS_W-1:0] {
        OK        = 3'b000,
        SKP_ADD   = 3'b001,
        SKP_REM   = 3'b010,
        RX_DETECT = 3'b011,
        DEC_ERR   = 3'b100,
        EB_OVF    = 3'b101,
        EB_UNF    = 3'b110,
        DISP_ERR  = 3'b111
    } rx_status_e;

    localparam logic [5:0] DBW_8    = 6'd8;
    localparam logic [5:0] DBW_16   = 6'd16;
    localparam logic [5:0] DBW_32   = 6'd32;
    localparam logic [2:0] BYTES_8  = 3'd1;
    localparam logic [2:0] BYTES_16 = 3'd2;
    localparam logic [2:0] BYTES_32 = 3'd4;

    // Returns 0 for any width that has no byte-count mapping.
    function automatic logic [2:0] width_to_bytes(input logic [5:0] dbw);
        logic [2:0] bytes;
        case (dbw)
            DBW_8:   bytes = BYTES_8;
            DBW_16:  bytes = BYTES_16;
            DBW_32:  bytes = BYTES_32;
            default: bytes = 3'd0;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/rx_status_merge.sv
// Combinational max-reduction of per-lane PIPE status codes over the lanes flagged valid.
// Zero latency; no flow control.
module rx_status_merge #(
    parameter int N  = 4,
    parameter int SW = 3
) (
    input  logic [N-1:0][SW-1:0] i_lane_st,
    input  logic [N-1:0]         i_lane_vld,
    output logic [SW-1:0]        o_status
);

    logic [SW-1:0] w_max;

    always_comb begin
        w_max = '0;
        for (int i = 0; i < N; i++) begin
            if (i_lane_vld[i] && (i_lane_st[i] > w_max)) begin
                w_max = i_lane_st[i];
            end
        end
    end

    assign o_status = w_max;

endmodule

// File: rtl/rx_symbol_packer.sv
// Packs decoded bytes into 8/16/32-bit PIPE RX words; outputs registered, strobe one cycle after the accepting edge,
// no backpressure (MAC takes every strobe). RX_PACKER_STATS_EN adds the saturating Err_Count output.
module rx_symbol_packer #(
    parameter int MAX_BYTES = 4,
    parameter int STATUS_W  = phy_pipe_pkg::STATUS_W
) (
    input  logic                   PCLK,
    input  logic                   Reset,
    input  logic [7:0]             Sym_Data,
    input  logic                   Sym_DataK,
    input  logic [STATUS_W-1:0]    Sym_Status,
    input  logic                   Sym_Valid,
    input  logic [5:0]             DataBusWidth,
    input  logic                   Flush,
    output logic [8*MAX_BYTES-1:0] Rx_Data,
    output logic [MAX_BYTES-1:0]   Rx_DataK,
    output logic [STATUS_W-1:0]    Rx_Status,
    output logic                   Rx_Valid,
    output logic                   Rx_Partial,
    output logic                   Width_Err
`ifdef RX_PACKER_STATS_EN
    ,
    output logic [15:0]            Err_Count
`endif
);
    import phy_pipe_pkg::*;

    localparam logic [2:0] MAXB = 3'(MAX_BYTES);

    logic [2:0]                         r_idx;
    logic [2:0]                         r_width;
    logic [MAX_BYTES-1:0][7:0]          r_lane_dat;
    logic [MAX_BYTES-1:0]               r_lane_k;
    logic [MAX_BYTES-1:0][STATUS_W-1:0] r_lane_st;

    logic [2:0]                         w_dec;
    logic                               w_bad;
    logic [2:0]                         w_eff_width;
    logic [2:0]                         w_cnt;
    logic                               w_complete;
    logic                               w_partial;
    logic                               w_emit;
    logic [MAX_BYTES-1:0][7:0]          w_nxt_dat;
    logic [MAX_BYTES-1:0]               w_nxt_k;
    logic [MAX_BYTES-1:0][STATUS_W-1:0] w_nxt_st;
    logic [MAX_BYTES-1:0]               w_mask;
    logic [MAX_BYTES-1:0][7:0]          w_out_dat;
    logic [MAX_BYTES-1:0]               w_out_k;
    logic [STATUS_W-1:0]                w_merged_st;

    assign w_dec = width_to_bytes(DataBusWidth);
    assign w_bad = (w_dec == 3'd0) || (w_dec > MAXB);

    // At index 0 the word being started uses the width sampled this very cycle.
    assign w_eff_width = (r_idx == 3'd0) ? (w_bad ? 3'd1 : w_dec) : r_width;
    assign w_cnt       = r_idx + 3'(Sym_Valid);
    assign w_complete  = Sym_Valid && (w_cnt == w_eff_width);
    assign w_partial   = Flush && !w_complete && (w_cnt != 3'd0);
    assign w_emit      = w_complete || w_partial;

    always_comb begin
        w_nxt_dat = r_lane_dat;
        w_nxt_k   = r_lane_k;
        w_nxt_st  = r_lane_st;
        w_mask    = '0;
        w_out_dat = '0;
        w_out_k   = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (Sym_Valid && (r_idx == 3'(i))) begin
                w_nxt_dat[i] = Sym_Data;
                w_nxt_k[i]   = Sym_DataK;
                w_nxt_st[i]  = Sym_Status;
            end
            w_mask[i] = (3'(i) < w_cnt);
            if (w_mask[i]) begin
                w_out_dat[i] = w_nxt_dat[i];
                w_out_k[i]   = w_nxt_k[i];
            end
        end
    end

    rx_status_merge #(
        .N  (MAX_BYTES),
        .SW (STATUS_W)
    ) u_status_merge (
        .i_lane_st  (w_nxt_st),
        .i_lane_vld (w_mask),
        .o_status   (w_merged_st)
    );

    always_ff @(posedge PCLK or posedge Reset) begin
        if (Reset) begin
            r_idx      <= 3'd0;
            r_width    <= 3'd1;
            r_lane_dat <= '0;
            r_lane_k   <= '0;
            r_lane_st  <= '0;
            Rx_Data    <= '0;
            Rx_DataK   <= '0;
            Rx_Status  <= '0;
            Rx_Valid   <= 1'b0;
            Rx_Partial <= 1'b0;
            Width_Err  <= 1'b0;
        end else begin
            if (r_idx == 3'd0) begin
                r_width   <= w_eff_width;
                Width_Err <= w_bad;
            end
            r_lane_dat <= w_nxt_dat;
            r_lane_k   <= w_nxt_k;
            r_lane_st  <= w_nxt_st;
            r_idx      <= w_emit ? 3'd0 : w_cnt;
            Rx_Valid   <= w_emit;
            if (w_emit) begin
                Rx_Data    <= w_out_dat;
                Rx_DataK   <= w_out_k;
                Rx_Status  <= w_merged_st;
                Rx_Partial <= w_partial;
            end
        end
    end

`ifdef RX_PACKER_STATS_EN
    always_ff @(posedge PCLK or posedge Reset) begin
        if (Reset) begin
            Err_Count <= 16'd0;
        end else if (Sym_Valid && (Sym_Status != '0) && (Err_Count != 16'hFFFF)) begin
            Err_Count <= Err_Count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_symbol_packer.sv
// Bench for rx_symbol_packer: directed scenarios plus randomized traffic against a queue-based word model.
module tb_rx_symbol_packer;
    import phy_pipe_pkg::*;

    logic        PCLK = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  Sym_Data = '0;
    logic        Sym_DataK = 1'b0;
    logic [2:0]  Sym_Status = '0;
    logic        Sym_Valid = 1'b0;
    logic [5:0]  DataBusWidth = 6'd32;
    logic        Flush = 1'b0;
    logic [31:0] Rx_Data;
    logic [3:0]  Rx_DataK;
    logic [2:0]  Rx_Status;
    logic        Rx_Valid;
    logic        Rx_Partial;
    logic        Width_Err;
`ifdef RX_PACKER_STATS_EN
    logic [15:0] Err_Count;
`endif

    rx_symbol_packer #(.MAX_BYTES(4), .STATUS_W(3)) dut (
        .PCLK         (PCLK),
        .Reset        (Reset),
        .Sym_Data     (Sym_Data),
        .Sym_DataK    (Sym_DataK),
        .Sym_Status   (Sym_Status),
        .Sym_Valid    (Sym_Valid),
        .DataBusWidth (DataBusWidth),
        .Flush        (Flush),
        .Rx_Data      (Rx_Data),
        .Rx_DataK     (Rx_DataK),
        .Rx_Status    (Rx_Status),
        .Rx_Valid     (Rx_Valid),
        .Rx_Partial   (Rx_Partial),
        .Width_Err    (Width_Err)
`ifdef RX_PACKER_STATS_EN
        ,
        .Err_Count    (Err_Count)
`endif
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0] d;
        logic       k;
        logic [2:0] s;
    } sym_t;

    sym_t        cur[$];
    int          m_width;
    logic        m_werr;
    int          m_errs;
    logic        exp_vld;
    logic [31:0] sh_dat;
    logic [3:0]  sh_k;
    logic [2:0]  sh_st;
    logic        sh_part;
    int          n_cmp;
    int          n_bad;

    function automatic int dec_width(input logic [5:0] w);
        case (w)
            6'd8:    return 1;
            6'd16:   return 2;
            6'd32:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] pick_width();
        case ($urandom_range(0, 9))
            0, 1, 2: return 6'd8;
            3, 4:    return 6'd16;
            5, 6, 7: return 6'd32;
            8:       return 6'd12;
            default: return 6'd48;
        endcase
    endfunction

    task automatic model_reset();
        cur.delete();
        m_width = 1;
        m_werr  = 1'b0;
        m_errs  = 0;
        exp_vld = 1'b0;
        sh_dat  = '0;
        sh_k    = '0;
        sh_st   = '0;
        sh_part = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge PCLK);
        Sym_Valid = 1'b0;
        Flush     = 1'b0;
        Reset     = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(negedge PCLK);
        Reset = 1'b0;
        model_reset();
    endtask

    // One PCLK: drive inputs, advance the word model, then sample 1ns after the rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic k,
                         input logic [2:0] s, input logic [5:0] w, input logic f);
        int b;
        @(negedge PCLK);
        Sym_Valid    = v;
        Sym_Data     = d;
        Sym_DataK    = k;
        Sym_Status   = s;
        DataBusWidth = w;
        Flush        = f;
        if (cur.size() == 0) begin
            b       = dec_width(w);
            m_werr  = (b == 0);
            m_width = (b == 0) ? 1 : b;
        end
        exp_vld = 1'b0;
        if (v) begin
            cur.push_back('{d, k, s});
            if (s != 3'd0 && m_errs < 65535) m_errs++;
        end
        if (cur.size() > 0 && (cur.size() == m_width || f)) begin
            exp_vld = 1'b1;
            sh_dat  = '0;
            sh_k    = '0;
            sh_st   = '0;
            foreach (cur[i]) begin
                sh_dat[8*i +: 8] = cur[i].d;
                sh_k[i]          = cur[i].k;
                if (cur[i].s > sh_st) sh_st = cur[i].s;
            end
            sh_part = (cur.size() != m_width);
            cur.delete();
        end
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({Rx_Data, Rx_DataK, Rx_Status, Rx_Valid, Rx_Partial, Width_Err} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h %b %0d v%b p%b e%b, want all 0",
                     Rx_Data, Rx_DataK, Rx_Status, Rx_Valid, Rx_Partial, Width_Err);
        end
        release_reset();
    endtask

    task automatic test_width32_k();
        cycle(1, 8'h11, 0, 0, 6'd32, 0);
        cycle(1, 8'h22, 0, 0, 6'd32, 0);
        cycle(1, 8'h33, 1, 0, 6'd32, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL w32_early_strobe: Rx_Valid=%b want 0", Rx_Valid);
        end
        cycle(1, 8'h44, 0, 0, 6'd32, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h44332211 || Rx_DataK !== 4'b0100 || Rx_Partial !== 1'b0) begin
            n_bad++;
            $display("FAIL w32_word: v%b data %h k %b p%b, want v1 44332211 0100 p0",
                     Rx_Valid, Rx_Data, Rx_DataK, Rx_Partial);
        end
        cycle(0, 8'h00, 0, 0, 6'd32, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b0 || Rx_Data !== 32'h44332211) begin
            n_bad++;
            $display("FAIL w32_single_pulse: v%b data %h, want v0 data held 44332211", Rx_Valid, Rx_Data);
        end
    endtask

    task automatic test_width16_status();
        cycle(1, 8'hAA, 0, DEC_ERR, 6'd16, 0);
        cycle(1, 8'hBB, 0, DISP_ERR, 6'd16, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h0000BBAA || Rx_Status !== 3'b111 || Rx_DataK !== 4'b0000) begin
            n_bad++;
            $display("FAIL w16_status: v%b data %h st %b k %b, want v1 0000bbaa 111 0000",
                     Rx_Valid, Rx_Data, Rx_Status, Rx_DataK);
        end
    endtask

    task automatic test_width_change();
        cycle(1, 8'hC1, 0, 0, 6'd32, 0);
        cycle(1, 8'hC2, 0, 0, 6'd32, 0);
        cycle(1, 8'hC3, 0, 0, 6'd8, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wchg_midword_emit: Rx_Valid=%b want 0", Rx_Valid);
        end
        cycle(1, 8'hC4, 0, 0, 6'd8, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'hC4C3C2C1) begin
            n_bad++;
            $display("FAIL wchg_old_width: v%b data %h, want v1 c4c3c2c1", Rx_Valid, Rx_Data);
        end
        cycle(1, 8'hC5, 0, 0, 6'd8, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h000000C5) begin
            n_bad++;
            $display("FAIL wchg_new_width: v%b data %h, want v1 000000c5", Rx_Valid, Rx_Data);
        end
    endtask

    task automatic test_flush();
        cycle(1, 8'h01, 0, 0, 6'd32, 0);
        cycle(1, 8'h02, 0, 0, 6'd32, 0);
        cycle(0, 8'h00, 0, 0, 6'd32, 1);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h00000201 || Rx_Partial !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_partial: v%b data %h p%b, want v1 00000201 p1", Rx_Valid, Rx_Data, Rx_Partial);
        end
        cycle(0, 8'h00, 0, 0, 6'd32, 1);
        n_cmp++;
        if (Rx_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idx0: Rx_Valid=%b want 0", Rx_Valid);
        end
        cycle(1, 8'h03, 0, 0, 6'd32, 0);
        cycle(1, 8'h04, 0, 0, 6'd32, 0);
        cycle(1, 8'h05, 0, 0, 6'd32, 0);
        cycle(1, 8'h06, 0, 0, 6'd32, 1);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h06050403 || Rx_Partial !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_completing: v%b data %h p%b, want v1 06050403 p0", Rx_Valid, Rx_Data, Rx_Partial);
        end
        cycle(1, 8'h07, 1, 0, 6'd32, 1);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h00000007 || Rx_DataK !== 4'b0001 || Rx_Partial !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_with_byte: v%b data %h k %b p%b, want v1 00000007 0001 p1",
                     Rx_Valid, Rx_Data, Rx_DataK, Rx_Partial);
        end
    endtask

    task automatic test_width_err();
        cycle(0, 8'h00, 0, 0, 6'd12, 0);
        n_cmp++;
        if (Width_Err !== 1'b1) begin
            n_bad++;
            $display("FAIL werr_set: Width_Err=%b want 1", Width_Err);
        end
        cycle(1, 8'h5A, 0, 0, 6'd12, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h0000005A) begin
            n_bad++;
            $display("FAIL werr_single1: v%b data %h, want v1 0000005a", Rx_Valid, Rx_Data);
        end
        cycle(1, 8'hA5, 0, 0, 6'd12, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h000000A5 || Width_Err !== 1'b1) begin
            n_bad++;
            $display("FAIL werr_single2: v%b data %h e%b, want v1 000000a5 e1", Rx_Valid, Rx_Data, Width_Err);
        end
        cycle(0, 8'h00, 0, 0, 6'd16, 0);
        n_cmp++;
        if (Width_Err !== 1'b0) begin
            n_bad++;
            $display("FAIL werr_clear: Width_Err=%b want 0", Width_Err);
        end
    endtask

    task automatic test_reset_midword();
        cycle(1, 8'hE1, 0, 3'd5, 6'd32, 0);
        cycle(1, 8'hE2, 1, 0, 6'd32, 0);
        apply_reset();
        n_cmp++;
        if ({Rx_Data, Rx_DataK, Rx_Status, Rx_Valid, Rx_Partial, Width_Err} !== 42'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h %b %0d v%b p%b e%b, want all 0",
                     Rx_Data, Rx_DataK, Rx_Status, Rx_Valid, Rx_Partial, Width_Err);
        end
        release_reset();
        cycle(0, 8'h00, 0, 0, 6'd32, 1);
        n_cmp++;
        if (Rx_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_emit: Rx_Valid=%b want 0", Rx_Valid);
        end
        cycle(1, 8'hF1, 0, 0, 6'd16, 0);
        cycle(1, 8'hF2, 0, 0, 6'd16, 0);
        n_cmp++;
        if (Rx_Valid !== 1'b1 || Rx_Data !== 32'h0000F2F1 || Rx_Status !== 3'd0 || Rx_DataK !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset_fresh_word: v%b data %h st %0d k %b, want v1 0000f2f1 0 0000",
                     Rx_Valid, Rx_Data, Rx_Status, Rx_DataK);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            cycle(1, b, 0, 0, 6'd8, 0);
            n_cmp++;
            if (Rx_Valid !== 1'b1 || Rx_Data !== {24'h0, b}) begin
                n_bad++;
                $display("FAIL b2b_%0d: v%b data %h, want v1 %h", i, Rx_Valid, Rx_Data, {24'h0, b});
            end
        end
    endtask

    task automatic test_random();
        logic v;
        logic f;
        logic [5:0] w;
        w = 6'd32;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) w = pick_width();
            cycle(v, 8'($urandom), 1'($urandom), 3'($urandom), w, f);
            n_cmp++;
            if (Rx_Valid !== exp_vld) begin
                n_bad++;
                $display("FAIL rand_valid@%0d: got %b want %b", i, Rx_Valid, exp_vld);
            end
            n_cmp++;
            if ({Rx_Data, Rx_DataK, Rx_Status, Rx_Partial} !== {sh_dat, sh_k, sh_st, sh_part}) begin
                n_bad++;
                $display("FAIL rand_word@%0d: got %h %b %0d p%b want %h %b %0d p%b", i,
                         Rx_Data, Rx_DataK, Rx_Status, Rx_Partial, sh_dat, sh_k, sh_st, sh_part);
            end
            n_cmp++;
            if (Width_Err !== m_werr) begin
                n_bad++;
                $display("FAIL rand_werr@%0d: got %b want %b", i, Width_Err, m_werr);
            end
        end
    endtask

`ifdef RX_PACKER_STATS_EN
    task automatic test_stats();
        apply_reset();
        release_reset();
        for (int i = 0; i < 100; i++) cycle(1, 8'($urandom), 0, DEC_ERR, 6'd8, 0);
        n_cmp++;
        if (Err_Count !== 16'(m_errs)) begin
            n_bad++;
            $display("FAIL stats_count: got %0d want %0d", Err_Count, m_errs);
        end
        for (int i = 0; i < 69900; i++) cycle(1, 8'($urandom), 0, DEC_ERR, 6'd8, 0);
        n_cmp++;
        if (Err_Count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL stats_saturate: got %h want ffff", Err_Count);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        test_reset();
        test_width32_k();
        test_width16_status();
        test_width_change();
        test_flush();
        test_width_err();
        test_reset_midword();
        test_back_to_back();
        test_random();
`ifdef RX_PACKER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_symbol_packer.md
# rx_symbol_packer

Receive-path packer between the 8b/10b decoder and the MAC-facing PIPE RX port. Collects one decoded byte per PCLK, with its K flag and decode status, into words of 8, 16 or 32 bits. The width is selected at runtime by DataBusWidth. Emits each completed word with per-byte K bits, a merged status and a one-cycle valid strobe. Generalises the fixed 32-bit Rx_Data/Rx_DataK/Rx_Status bundle of the PHY to a parametrised, width-switchable, flushable packer.

## Interface
Parameters:
- MAX_BYTES, 4, maximum bytes per output word; legal values 1, 2, 4.
- STATUS_W, 3, width of the PIPE RX status code.

Ports:
- PCLK  in  1  the block's single clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Sym_Data  in  8  decoded byte.
- Sym_DataK  in  1  byte is a control (K) symbol.
- Sym_Status  in  STATUS_W  per-byte decode status; 000 means OK.
- Sym_Valid  in  1  Sym_* fields valid this cycle.
- DataBusWidth  in  6  requested word width in bits: 8, 16 or 32.
- Flush  in  1  emit the current partial word.
- Rx_Data  out  8*MAX_BYTES  packed word; the first-received byte is in [7:0].
- Rx_DataK  out  MAX_BYTES  per-byte K flags.
- Rx_Status  out  STATUS_W  merged status of the word.
- Rx_Valid  out  1  one-cycle strobe; Rx_* fields valid.
- Rx_Partial  out  1  with Rx_Valid: word was cut short by Flush.
- Width_Err  out  1  registered; DataBusWidth illegal at the last word boundary.

## Operation
- Reset values: all outputs 0. Byte index = 0. Latched width = 1 byte. Accumulator cleared.
- Width latch:
  - DataBusWidth is sampled only at a word boundary, i.e. when the byte index is 0 and Sym_Valid=1, or when the block is idle at index 0.
  - Mapping: 8 → 1 byte, 16 → 2 bytes, 32 → 4 bytes.
  - Any other value, or a width above MAX_BYTES*8, → 1 byte and Width_Err=1.
  - Width_Err stays 1 until the next boundary that samples a legal value.
- A width change mid-word takes effect at the next boundary; the current word completes at the width already latched.
- Accept: on Sym_Valid=1, the byte goes into lane [index]; the lane's K bit and status are stored; index increments.
- Complete: when index reaches the latched width, the word is emitted and index returns to 0.
- Lanes at or above the latched width in an emitted word: data 0x00, K=0.
- Status merge: Rx_Status is the numerically largest Sym_Status among the word's valid lanes. PIPE codes are ordered so that larger means more severe.
- Flush:
  - Index > 0: the partial word is emitted with unfilled lanes zero, Rx_Partial=1, and index returns to 0.
  - Index = 0: no effect.
- Flush with Sym_Valid in the same cycle:
  - The byte is accepted first.
  - If that byte completes the word: normal emit, Rx_Partial=0, no second strobe.
  - Otherwise: partial emit including that byte.
- Sym_Valid=0 holds state; there is no timeout.
- Reset mid-word discards the partial word; no emit.

## Timing
- Latency: Rx_Valid rises one PCLK after the edge that accepts the completing byte, or after the Flush edge. All outputs are registered.
- Rx_Valid is high for exactly one cycle per word. Rx_Data, Rx_DataK, Rx_Status and Rx_Partial hold their values until the next emit.
- Throughput: 1-byte width emits every accepted byte; back-to-back emits are allowed.
- There is no backpressure; the MAC must accept every strobe.

## Configuration
- RX_PACKER_STATS_EN defined:
  - Adds output Err_Count [15:0]: a saturating count of accepted bytes with Sym_Status != 0.
  - Saturates at 0xFFFF. Reset to 0. Increments in the accept cycle.
- RX_PACKER_STATS_EN undefined: the port and the counter are absent.

## Structure
- Shared package phy_pipe_pkg holds:
  - the STATUS_W constant;
  - the status code enum: OK=000, SKP_ADD=001, SKP_REM=010, RX_DETECT=011, DEC_ERR=100, EB_OVF=101, EB_UNF=110, DISP_ERR=111;
  - width-to-byte-count constants.
- Sub-module rx_status_merge: combinational max-reduction over MAX_BYTES lane status codes with a lane-valid mask.

## Test plan
- Width 32; bytes 0x11, 0x22, 0x33 (K), 0x44 → after the 4th byte plus one cycle: Rx_Data=0x44332211, Rx_DataK=4'b0100, Rx_Valid pulses once.
- Width 16; byte 0xAA with status 100, byte 0xBB with status 111 → Rx_Data[15:0]=0xBBAA, Rx_Status=111, upper lanes 0.
- Width 32; 2 bytes, then DataBusWidth changes to 8, then 2 more bytes → one 32-bit word, then later bytes emit singly.
- Width 32; bytes 0x01 and 0x02, then Flush → Rx_Data=0x00000201, Rx_Partial=1. Flush at index 0 → no strobe.
- DataBusWidth=12 at a boundary → Width_Err=1, each byte emitted singly. Reset mid-word → all outputs 0, no emit.
- RX_PACKER_STATS_EN: 70000 bytes with status 100 → Err_Count=0xFFFF.
